// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice, LSB nibble first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       slice;

  // The single shared 4-bit ripple-carry slice; bit 4 is the nibble carry-out.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    logic [4:0] r;
    logic       cc;
    r  = '0;
    cc = c;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    r[4] = cc;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    nib_a   = '0;
    nib_b   = '0;

    for (int k = 0; k < NIB; k++) begin
      if (cnt_q == CW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
    slice = ripple4(nib_a, nib_b, carry_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          cnt_d = '0;
          s_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
          // Subtract as A + ~B + 1; Co then reads as "no borrow".
          if (sub) begin
            b_d     = ~B;
            carry_d = 1'b1;
          end else begin
            b_d     = B;
            carry_d = Ci;
          end
`else
          b_d     = B;
          carry_d = Ci;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NIB; k++) begin
          if (cnt_q == CW'(k)) s_d[4*k +: 4] = slice[3:0];
        end
        carry_d = slice[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          co_d    = slice[4];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  // Latched operands are only read while RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign S         = s_q;
  assign Co        = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized bench for nibble_serial_adder against an arithmetic reference.
// Subtract checks are included when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Ci, out_valid, out_ready, Co, busy, sub;
  logic [W-1:0] A, B, S;

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic; subtract gives Co=1 when no borrow.
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci, input logic sb);
    logic [W:0] r;
    if (sb) r = {(a >= b), W'(a - b)};
    else    r = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    return r;
  endfunction

  // One full transaction: accept, check latency, optional stall in DONE, release.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, input int stall, input string tag);
    logic [W:0] exp;
    exp = ref_result(a, b, ci, sb);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    A = a; B = b; Ci = ci; sub = sb; in_valid = 1'b1;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Ci = 1'($urandom); sub = 1'($urandom);
    for (int i = 1; i < NIB; i++) begin
      step();
      check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_S"}, 32'(S), 32'(exp[W-1:0]));
    check({tag, "_Co"}, 32'(Co), 32'(exp[W]));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_S"}, 32'(S), 32'(exp[W-1:0]));
      check({tag, "_hold_Co"}, 32'(Co), 32'(exp[W]));
    end
    out_ready = 1'b1;
    step();
    check({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; Ci = 1'b0; sub = 1'b0;
    A = '0; B = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_Co", 32'(Co), 32'd0);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap_b");
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "wrap_ci");

    // Backpressure with in_valid held high throughout DONE.
    A = 16'h0F0F; B = 16'h00F1; Ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 0; i < NIB; i++) step();
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_S", 32'(S), 32'h1000);
      check("bp_Co", 32'(Co), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    A = 16'h0002; B = 16'h0003;
    out_ready = 1'b1;
    step();
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_busy", 32'(busy), 32'd0);
    step();
    check("bp_new_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < NIB; i++) step();
    check("bp_new_S", 32'(S), 32'h0005);
    step();

    // Reset in the middle of RUN aborts the operation.
    A = 16'h8888; B = 16'h8888; Ci = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_S", 32'(S), 32'd0);
    check("abort_Co", 32'(Co), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_abort");

    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, "b2b0");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "b2b1");
    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, "b2b2");

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_borrow");
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1, "sub_noborrow");
`endif

    for (int n = 0; n < 25; n++) begin
      logic sb;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), sb, int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
